// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter and registered command stage for the single-port 128b x 2048 SRAM.
// Define SRAM_RR_ARB_CLEAR_EN to include the zero-fill clear sequencer (CLEAR state).
module sram_rr_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 128,
    parameter int CLR_DEPTH = 36
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    logic              last;
    logic              arb_en;
    logic              clr_wr;
    logic [ADDR_W-1:0] clr_addr;
    logic              rd_v1;
    logic              rd_tag1;

`ifdef SRAM_RR_ARB_CLEAR_EN
    localparam int CNT_W = (CLR_DEPTH > 1) ? $clog2(CLR_DEPTH) : 1;

    typedef enum logic {ARB, CLEAR} state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] clr_cnt;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= ARB;
            clr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR && next_state == CLEAR)
                clr_cnt <= clr_cnt + CNT_W'(1);
            else
                clr_cnt <= '0;
        end
    end

    // clr_start takes the cycle away from arbitration; CLEAR ignores further pulses
    always_comb begin
        next_state = state;
        arb_en     = 1'b0;
        clr_wr     = 1'b0;
        clr_busy   = 1'b0;
        case (state)
            ARB: begin
                if (clr_start)
                    next_state = CLEAR;
                else
                    arb_en = 1'b1;
            end
            CLEAR: begin
                clr_busy = 1'b1;
                clr_wr   = 1'b1;
                if (clr_cnt == CNT_W'(CLR_DEPTH - 1))
                    next_state = ARB;
            end
            default: next_state = ARB;
        endcase
    end

    assign clr_addr = ADDR_W'(clr_cnt);
`else
    logic unused_clr;

    assign unused_clr = clr_start ^ (CLR_DEPTH == 0);
    assign arb_en     = 1'b1;
    assign clr_wr     = 1'b0;
    assign clr_busy   = 1'b0;
    assign clr_addr   = '0;
`endif

    // Grants are suppressed during reset so a requester never drops a request that gets flushed
    assign gnt0 = arb_en && !reset && req0 && (!req1 || last);
    assign gnt1 = arb_en && !reset && req1 && (!req0 || !last);

    always_ff @(posedge CLK) begin
        if (reset)
            last <= 1'b1;
        else if (gnt0)
            last <= 1'b0;
        else if (gnt1)
            last <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            sram_a   <= '0;
            sram_d   <= '0;
        end else if (clr_wr) begin
            sram_cen <= 1'b0;
            sram_wen <= 1'b0;
            sram_a   <= clr_addr;
            sram_d   <= '0;
        end else if (gnt0) begin
            sram_cen <= 1'b0;
            sram_wen <= ~we0;
            sram_a   <= addr0;
            sram_d   <= we0 ? wdata0 : '0;
        end else if (gnt1) begin
            sram_cen <= 1'b0;
            sram_wen <= ~we1;
            sram_a   <= addr1;
            sram_d   <= we1 ? wdata1 : '0;
        end else begin
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
        end
    end

    // Tag follows the command through the SRAM's one-cycle access to steer rvalid
    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_v1   <= 1'b0;
            rd_tag1 <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rd_v1   <= (gnt0 && !we0) || (gnt1 && !we1);
            rd_tag1 <= gnt1;
            rvalid0 <= rd_v1 && !rd_tag1;
            rvalid1 <= rd_v1 && rd_tag1;
        end
    end

    assign rdata = sram_q;

endmodule
